// File: rtl/onoff_run_monitor.sv
// rtl/onoff_run_monitor.sv - ON/OFF level monitor: edge pulses, ON-run length, long-run flag, ON-entry count
module onoff_run_monitor #(
    parameter int CNT_W    = 8,
    parameter int LONG_LEN = 4,
    parameter int EVT_W    = 8
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             in,
    input  logic             clr,
    output logic             rise,
    output logic             fall,
    output logic             run_valid,
    output logic [CNT_W-1:0] run_len,
    output logic             long_flag,
    output logic [EVT_W-1:0] on_count,
    output logic             busy
);
    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_ON      = 2'd1,
        ST_ON_LONG = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_V  = CNT_W'(LONG_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [EVT_W-1:0] EVT_MAX = {EVT_W{1'b1}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d, cnt_inc;
    logic             in_d;
    logic             rise_d, fall_d, long_d, busy_d;

    // in_d tracks the previous sample; it is nonzero exactly when the FSM is out of OFF
    always_ff @(posedge clk) begin
        if (areset) begin
            state_q   <= ST_OFF;
            run_cnt_q <= '0;
            in_d      <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            in_d      <= in;
        end
    end

    assign cnt_inc = (run_cnt_q == CNT_MAX) ? CNT_MAX : run_cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        case (state_q)
            ST_OFF: begin
                if (in) begin
                    state_d   = (LONG_V == CNT_W'(1)) ? ST_ON_LONG : ST_ON;
                    run_cnt_d = CNT_W'(1);
                end
            end
            ST_ON: begin
                if (in) begin
                    run_cnt_d = cnt_inc;
                    if (cnt_inc == LONG_V)
                        state_d = ST_ON_LONG;
                end else begin
                    state_d   = ST_OFF;
                    run_cnt_d = '0;
                end
            end
            ST_ON_LONG: begin
                if (in) begin
                    run_cnt_d = cnt_inc;
                end else begin
                    state_d   = ST_OFF;
                    run_cnt_d = '0;
                end
            end
            default: begin
                state_d   = ST_OFF;
                run_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        rise_d = in & ~in_d;
        fall_d = ~in & in_d;
        busy_d = in;
        long_d = (state_d == ST_ON_LONG);
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            rise      <= 1'b0;
            fall      <= 1'b0;
            run_valid <= 1'b0;
            long_flag <= 1'b0;
            busy      <= 1'b0;
            run_len   <= '0;
            on_count  <= '0;
        end else begin
            rise      <= rise_d;
            fall      <= fall_d;
            run_valid <= fall_d;
            long_flag <= long_d;
            busy      <= busy_d;
            // A completing run takes priority over clr so the new length is not lost
            if (fall_d)
                run_len <= run_cnt_q;
            else if (clr)
                run_len <= '0;
            if (clr)
                on_count <= rise_d ? EVT_W'(1) : '0;
            else if (rise_d && on_count != EVT_MAX)
                on_count <= on_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_onoff_run_monitor.sv
// tb/tb_onoff_run_monitor.sv - directed self-checking bench for onoff_run_monitor
module tb_onoff_run_monitor;
    logic       clk = 1'b0;
    logic       areset, in_s, clr;
    logic       rise, fall, run_valid, long_flag, busy;
    logic [7:0] run_len, on_count;
    int         checks = 0;
    int         failures = 0;

    onoff_run_monitor #(.CNT_W(8), .LONG_LEN(4), .EVT_W(8)) dut (
        .clk(clk), .areset(areset), .in(in_s), .clr(clr),
        .rise(rise), .fall(fall), .run_valid(run_valid), .run_len(run_len),
        .long_flag(long_flag), .on_count(on_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step(input logic i, input logic c, input logic r);
        in_s = i; clr = c; areset = r;
        @(posedge clk);
        #1;
    endtask

    // expected fields: rise fall run_valid long_flag busy run_len on_count
    task automatic chk(input string tag, input logic er, input logic ef, input logic ev,
                       input logic el, input logic eb, input logic [7:0] erl, input logic [7:0] eoc);
        logic [20:0] obs, exp;
        obs = {rise, fall, run_valid, long_flag, busy, run_len, on_count};
        exp = {er, ef, ev, el, eb, erl, eoc};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%06h expected=%06h", tag, obs, exp);
        end
    endtask

    initial begin
        in_s = 1'b0; clr = 1'b0; areset = 1'b1;
        step(0, 0, 1);
        step(0, 0, 1);
        chk("reset", 0, 0, 0, 0, 0, 8'd0, 8'd0);
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 0);
            chk("idle", 0, 0, 0, 0, 0, 8'd0, 8'd0);
        end

        // 3-sample run
        step(1, 0, 0); chk("r3_s1", 1, 0, 0, 0, 1, 8'd0, 8'd1);
        step(1, 0, 0); chk("r3_s2", 0, 0, 0, 0, 1, 8'd0, 8'd1);
        step(1, 0, 0); chk("r3_s3", 0, 0, 0, 0, 1, 8'd0, 8'd1);
        step(0, 0, 0); chk("r3_fall", 0, 1, 1, 0, 0, 8'd3, 8'd1);
        step(0, 0, 0); chk("r3_after", 0, 0, 0, 0, 0, 8'd3, 8'd1);

        // 6-sample run, long_flag from 4th sample
        step(1, 0, 0); chk("r6_s1", 1, 0, 0, 0, 1, 8'd3, 8'd2);
        step(1, 0, 0); chk("r6_s2", 0, 0, 0, 0, 1, 8'd3, 8'd2);
        step(1, 0, 0); chk("r6_s3", 0, 0, 0, 0, 1, 8'd3, 8'd2);
        step(1, 0, 0); chk("r6_s4", 0, 0, 0, 1, 1, 8'd3, 8'd2);
        step(1, 0, 0); chk("r6_s5", 0, 0, 0, 1, 1, 8'd3, 8'd2);
        step(1, 0, 0); chk("r6_s6", 0, 0, 0, 1, 1, 8'd3, 8'd2);
        step(0, 0, 0); chk("r6_fall", 0, 1, 1, 0, 0, 8'd6, 8'd2);
        step(0, 0, 0); chk("r6_after", 0, 0, 0, 0, 0, 8'd6, 8'd2);

        // 300-sample run saturates run_len
        for (int k = 1; k <= 300; k++) begin
            step(1, 0, 0);
            chk("r300", (k == 1), 0, 0, (k >= 4), 1, 8'd6, 8'd3);
        end
        step(0, 0, 0); chk("r300_fall", 0, 1, 1, 0, 0, 8'd255, 8'd3);

        // four 2-sample pulses, clr on the 4th rising sample
        for (int p = 1; p <= 4; p++) begin
            step(1, (p == 4), 0);
            chk("pc_rise", 1, 0, 0, 0, 1, (p == 1) ? 8'd255 : (p == 4) ? 8'd0 : 8'd2,
                (p == 4) ? 8'd1 : 8'(3 + p));
            step(1, 0, 0);
            step(0, 0, 0);
            chk("pc_fall", 0, 1, 1, 0, 0, 8'd2, (p == 4) ? 8'd1 : 8'(3 + p));
            step(0, 0, 0);
        end

        // clr alone clears statistics
        step(0, 1, 0); chk("clr_only", 0, 0, 0, 0, 0, 8'd0, 8'd0);

        // same sequence without clr
        for (int p = 1; p <= 4; p++) begin
            step(1, 0, 0);
            chk("pn_rise", 1, 0, 0, 0, 1, (p == 1) ? 8'd0 : 8'd2, 8'(p));
            step(1, 0, 0);
            step(0, 0, 0);
            chk("pn_fall", 0, 1, 1, 0, 0, 8'd2, 8'(p));
            step(0, 0, 0);
        end

        // clr coincident with run completion keeps the new length
        step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
        step(0, 1, 0); chk("clr_fall", 0, 1, 1, 0, 0, 8'd3, 8'd0);

        // areset mid-run aborts without fall; held-high input is a new rise
        step(1, 0, 0); step(1, 0, 0);
        step(1, 1, 1); chk("areset_mid", 0, 0, 0, 0, 0, 8'd0, 8'd0);
        step(1, 0, 0); chk("post_rst_rise", 1, 0, 0, 0, 1, 8'd0, 8'd1);
        step(0, 0, 0); chk("one_sample_run", 0, 1, 1, 0, 0, 8'd1, 8'd1);
        step(0, 0, 0); chk("pulse_width", 0, 0, 0, 0, 0, 8'd1, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/onoff_run_monitor.md
Name: onoff_run_monitor

Overview:
- Downstream consumer of the two-state ON/OFF FSM's 1-bit `out`.
- Samples that level every clock, flags its edges, measures each ON run in cycles, raises a long-run flag, and keeps a saturating count of ON entries.
- Feeds status/debug logic; all outputs are registered.

Parameters:
- CNT_W, 8, width of run-length counter and run_len output
- LONG_LEN, 4, ON-run length (in samples) at which long_flag asserts; legal range 1..2^CNT_W-1
- EVT_W, 8, width of on_count

Ports:
- clk  input  1  system clock, all logic on rising edge
- areset  input  1  synchronous, active-high reset; sampled on rising clk edge, overrides every other input
- in  input  1  ON/OFF level from upstream FSM (`out`)
- clr  input  1  synchronous clear of statistics (on_count, run_len)
- rise  output  1  one-cycle pulse: in went 0->1
- fall  output  1  one-cycle pulse: in went 1->0
- run_valid  output  1  one-cycle pulse, coincident with fall: run_len updated
- run_len  output  CNT_W  length of last completed ON run, in samples
- long_flag  output  1  level: current ON run has reached LONG_LEN samples
- on_count  output  EVT_W  number of 0->1 transitions since reset/clr
- busy  output  1  level: monitor is in an ON run

Behaviour:
- Sample s[n] = in at clock edge n; in_d register holds s[n-1]; reset value of in_d = 0.
- Every output is 0 after reset. All outputs are registered and reflect sample n in the cycle after edge n (latency 1).
- FSM states: OFF, ON, ON_LONG. Reset state is OFF.
- OFF: if s=1, go to ON, set run_cnt=1, pulse rise, busy=1.
- ON: if s=1, run_cnt+1 (saturating at 2^CNT_W-1). When the incremented value equals LONG_LEN, go to ON_LONG with long_flag=1.
- ON with LONG_LEN=1: entering from OFF goes straight to ON_LONG, and long_flag asserts together with rise.
- ON/ON_LONG: if s=0, go to OFF. run_len <= run_cnt, pulse fall and run_valid, clear long_flag and busy.
- ON_LONG: if s=1, keep counting (saturating); long_flag stays 1.
- rise and fall are exactly one cycle wide. A 1-sample ON run gives rise in cycle k and fall/run_valid in cycle k+1, with run_len=1.
- on_count: +1 on each rise, saturating at 2^EVT_W-1, never wraps.
- clr clears on_count and run_len. It does not affect FSM state, run_cnt, long_flag or busy.
- clr in the same cycle as a rise: on_count becomes 1 (clear, then count the new rise).
- clr in the same cycle as a run completion: run_len takes the new completed value and run_valid pulses.
- areset mid-run: state goes to OFF, run_cnt=0, in_d=0, all outputs 0. The aborted run produces no run_valid and no fall.
  - If in is still 1 on the first sample after reset releases, that is a new rise.
- areset and clr together: areset wins.

Test Plan:
- (Defaults CNT_W=8, LONG_LEN=4, EVT_W=8.) Hold areset 2 cycles, in=0 for 10 cycles -> rise=fall=run_valid=long_flag=busy=0, run_len=0, on_count=0 throughout.
- in=1 for 3 samples, then 0 -> rise one cycle after first high sample, busy high 3 cycles; fall=run_valid=1 for one cycle after first low sample with run_len=3; long_flag never 1; on_count=1.
- in=1 for 6 samples, then 0 -> long_flag rises the cycle after the 4th high sample, stays high until the fall cycle; run_len=6.
- in=1 for 300 samples, then 0 -> run_len=255 (saturated); long_flag high from sample 4 to fall; on_count increments by exactly 1.
- Four 2-sample pulses separated by 2 low samples, clr asserted in the cycle of the 4th rising sample -> on_count=1 afterwards; the same sequence without clr -> on_count=4, run_len=2 after each fall.
- in=1 for 2 samples, assert areset for 1 cycle while in stays 1, then release -> next cycle all outputs 0, no run_valid; the following sample gives rise=1, on_count=1, busy=1.
